// File: rtl/if_fetch_queue.sv
// IF-stage fetch queue: one outstanding imem read per pc, {pc,instr} FIFO towards ID.
// Define IF_BYPASS_EN to forward a response straight to ID when the FIFO is empty.
module if_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            pc,
    input  logic                       flush,
    output logic                       PC_Write,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_instr,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] StFetch = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            grant, push_resp, wr_en, rd_en;

    assign imem_addr = pc;
    assign imem_req  = ~rst & (state_q == StFetch) & (count_q < FULL) & ~flush;
    assign grant     = imem_req & imem_gnt;
    // pc must stay put until the request at this address has been accepted
    assign PC_Write  = flush | grant;
    assign push_resp = (state_q == StWait) & imem_rvalid & ~flush;
    assign rd_en     = (count_q != '0) & id_ready;
    assign count     = count_q;

`ifdef IF_BYPASS_EN
    logic bypass;
    assign bypass   = push_resp & (count_q == '0);
    assign id_valid = (count_q != '0) | bypass;
    assign id_pc    = bypass ? addr_q : pc_mem[rd_ptr_q];
    assign id_instr = bypass ? imem_rdata : instr_mem[rd_ptr_q];
    // a bypassed response taken by ID never occupies a slot
    assign wr_en    = push_resp & ~(bypass & id_ready);
`else
    assign id_valid = (count_q != '0);
    assign id_pc    = pc_mem[rd_ptr_q];
    assign id_instr = instr_mem[rd_ptr_q];
    assign wr_en    = push_resp;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: if (grant) state_d = StWait;
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StFetch;
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: if (imem_rvalid) state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFetch;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                addr_q <= pc;
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (rd_en) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_q + CW'(wr_en) - CW'(rd_en);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (wr_en) begin
            pc_mem[wr_ptr_q]    <= addr_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
